// File: rtl/cmp_operand_seq.sv
// cmp_operand_seq
//   Multi-cycle compare-operand sequencer. Computes S = A - B digit-serially,
//   DIGIT_W bits per cycle (LSB first). It also produces the overflow-corrected
//   signed less-than flag and passes the set-condition code through as the
//   comparator mask.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   start  in   launch request, sampled while not busy (IDLE or DONE)
//   A, B   in   32-bit two's complement operands (minuend, subtrahend)
//   cond   in   3-bit set-condition select
//   busy   out  high during the N RUN cycles
//   done   out  one-cycle pulse; S/neg/F valid from this cycle on
//   S      out  A - B modulo 2^32
//   neg    out  signed A < B
//   F      out  condition mask {lt, eq, gt} latched from cond
module cmp_operand_seq #(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  cond,
  output logic        busy,
  output logic        done,
  output logic [31:0] S,
  output logic        neg,
  output logic [2:0]  F
);

  localparam int unsigned N     = 32 / DIGIT_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [2:0]         cond_q;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        w;

  logic [5:0]         bit_idx;
  logic [DIGIT_W:0]   sum;
  logic [31:0]        w_nxt;
  logic               last;
  logic               accept;
  logic               ovf;

  // Digit slice position of the current RUN cycle.
  assign bit_idx = 6'(cnt) * 6'(DIGIT_W);
  assign last    = (cnt == CNT_W'(N - 1));
  assign accept  = start && (state != ST_RUN);

  // One digit of A + ~B + carry; carry is preset to 1 at launch.
  always_comb begin
    sum = {1'b0, a_q[bit_idx +: DIGIT_W]}
        + {1'b0, ~b_q[bit_idx +: DIGIT_W]}
        + {{DIGIT_W{1'b0}}, carry};
  end

  // Work register with the current digit merged in; on the last digit this
  // is the final difference, so S can be loaded on the same edge.
  always_comb begin
    w_nxt = w;
    w_nxt[bit_idx +: DIGIT_W] = sum[DIGIT_W-1:0];
  end

  assign ovf = (a_q[31] != b_q[31]) && (w_nxt[31] != a_q[31]);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      cond_q <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      w      <= '0;
      S      <= '0;
      neg    <= 1'b0;
      F      <= '0;
    end else if (accept) begin
      a_q    <= A;
      b_q    <= B;
      cond_q <= cond;
      carry  <= 1'b1;
      cnt    <= '0;
    end else if (state == ST_RUN) begin
      w     <= w_nxt;
      carry <= sum[DIGIT_W];
      if (last) begin
        S   <= w_nxt;
        neg <= w_nxt[31] ^ ovf;
        F   <= cond_q;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cmp_operand_seq.sv
// tb_cmp_operand_seq
//   Scoreboard bench for cmp_operand_seq. Three instances (DIGIT_W = 4, 1, 32)
//   share clock, reset and operand inputs; each has its own start.
module tb_cmp_operand_seq;

  typedef struct packed {
    logic [31:0] s;
    logic        neg;
    logic [2:0]  f;
  } res_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      A;
  logic [31:0]      B;
  logic [2:0]       cond;
  logic [2:0]       start_v;
  logic [2:0]       busy_v;
  logic [2:0]       done_v;
  logic [2:0][31:0] s_v;
  logic [2:0]       neg_v;
  logic [2:0][2:0]  f_v;

  res_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cmp_operand_seq #(.DIGIT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start_v[0]), .A(A), .B(B), .cond(cond),
    .busy(busy_v[0]), .done(done_v[0]), .S(s_v[0]), .neg(neg_v[0]), .F(f_v[0])
  );

  cmp_operand_seq #(.DIGIT_W(1)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .A(A), .B(B), .cond(cond),
    .busy(busy_v[1]), .done(done_v[1]), .S(s_v[1]), .neg(neg_v[1]), .F(f_v[1])
  );

  cmp_operand_seq #(.DIGIT_W(32)) dut32 (
    .clk(clk), .reset(reset), .start(start_v[2]), .A(A), .B(B), .cond(cond),
    .busy(busy_v[2]), .done(done_v[2]), .S(s_v[2]), .neg(neg_v[2]), .F(f_v[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    res_t r;
    r.s   = a - b;
    r.neg = ($signed(a) < $signed(b));
    r.f   = c;
    return r;
  endfunction

  // Drives one start pulse on instance d; returns at the negedge of cycle k+1.
  task automatic drive_start(input int d, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] c, input bit push);
    @(negedge clk);
    A = a; B = b; cond = c;
    start_v[d] = 1'b1;
    if (push) exp_q.push_back(model(a, b, c));
    @(negedge clk);
    start_v[d] = 1'b0;
  endtask

  // Samples at successive negedges, first one numbered c0, until done is seen;
  // then compares outputs against the scoreboard head.
  task automatic wait_done(input int d, input int c0, input int budget,
                           output int lat, output int nbusy);
    res_t e;
    lat   = -1;
    nbusy = 0;
    for (int c = c0; c < c0 + budget; c++) begin
      if (done_v[d]) begin
        lat = c;
        check("busy_in_done", 32'(busy_v[d]), 32'd0);
        if (exp_q.size() == 0) begin
          check("sb_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("S",   s_v[d],          e.s);
          check("neg", 32'(neg_v[d]),   32'(e.neg));
          check("F",   32'(f_v[d]),     32'(e.f));
        end
        break;
      end
      if (busy_v[d]) nbusy++;
      @(negedge clk);
    end
    if (lat < 0) check("done_seen", 32'(done_v[d]), 32'd1);
  endtask

  int lat, nb, lat2, nb2, ndone, nbusy_idle;

  initial begin
    reset   = 1'b1;
    start_v = '0;
    A       = '0;
    B       = '0;
    cond    = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_busy", 32'(busy_v[d]), 32'd0);
      check("rst_done", 32'(done_v[d]), 32'd0);
      check("rst_S",    s_v[d],         32'd0);
      check("rst_neg",  32'(neg_v[d]),  32'd0);
      check("rst_F",    32'(f_v[d]),    32'd0);
    end
    reset = 1'b0;

    // Basic subtract with latency and busy length
    drive_start(0, 32'd5, 32'd3, 3'b011, 1);
    wait_done(0, 1, 40, lat, nb);
    check("lat_5m3", 32'(lat), 32'd9);
    check("busy_5m3", 32'(nb), 32'd8);

    // Negative result, then outputs held while idle
    drive_start(0, 32'd3, 32'd5, 3'b100, 1);
    wait_done(0, 1, 40, lat, nb);
    check("lat_3m5", 32'(lat), 32'd9);
    ndone = 0;
    nbusy_idle = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
      if (busy_v[0]) nbusy_idle++;
    end
    check("idle_done", 32'(ndone), 32'd0);
    check("idle_busy", 32'(nbusy_idle), 32'd0);
    check("hold_S",   s_v[0],        32'hFFFF_FFFE);
    check("hold_neg", 32'(neg_v[0]), 32'd1);
    check("hold_F",   32'(f_v[0]),   32'd4);

    // Overflow corner cases
    drive_start(0, 32'h8000_0000, 32'h0000_0001, 3'b100, 1);
    wait_done(0, 1, 40, lat, nb);
    drive_start(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b001, 1);
    wait_done(0, 1, 40, lat, nb);

    // Equal operands on all three digit widths
    drive_start(0, 32'h0000_1234, 32'h0000_1234, 3'b010, 1);
    wait_done(0, 1, 40, lat, nb);
    drive_start(1, 32'h0000_1234, 32'h0000_1234, 3'b010, 1);
    wait_done(1, 1, 80, lat, nb);
    check("lat_dw1", 32'(lat), 32'd33);
    check("busy_dw1", 32'(nb), 32'd32);
    drive_start(2, 32'h0000_1234, 32'h0000_1234, 3'b010, 1);
    wait_done(2, 1, 40, lat, nb);
    check("lat_dw32", 32'(lat), 32'd2);
    check("busy_dw32", 32'(nb), 32'd1);
    drive_start(2, 32'h1234_5678, 32'h9ABC_DEF0, 3'b101, 1);
    wait_done(2, 1, 40, lat, nb);

    // start with new operands during RUN cycle 3 is ignored
    drive_start(0, 32'h0000_0100, 32'h0000_0040, 3'b001, 1);
    @(negedge clk);
    @(negedge clk);
    A = 32'h0000_0001; B = 32'h7000_0000; cond = 3'b111;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 4, 40, lat, nb);
    check("lat_ignore", 32'(lat), 32'd9);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    check("extra_done", 32'(ndone), 32'd0);

    // Asynchronous reset in RUN cycle 4
    drive_start(0, 32'hDEAD_0000, 32'h0000_1234, 3'b110, 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy_v[0]), 32'd0);
    check("arst_done", 32'(done_v[0]), 32'd0);
    check("arst_S",    s_v[0],         32'd0);
    check("arst_neg",  32'(neg_v[0]),  32'd0);
    check("arst_F",    32'(f_v[0]),    32'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    nbusy_idle = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
      if (busy_v[0]) nbusy_idle++;
    end
    check("arst_nodone", 32'(ndone), 32'd0);
    check("arst_nobusy", 32'(nbusy_idle), 32'd0);

    // Back-to-back: start held through the DONE cycle, operands changed
    // after the first launch edge
    @(negedge clk);
    A = 32'h0000_0010; B = 32'h0000_0020; cond = 3'b100;
    start_v[0] = 1'b1;
    exp_q.push_back(model(32'h0000_0010, 32'h0000_0020, 3'b100));
    @(negedge clk);
    A = 32'hFFFF_FFF0; B = 32'h0000_0007; cond = 3'b110;
    exp_q.push_back(model(32'hFFFF_FFF0, 32'h0000_0007, 3'b110));
    wait_done(0, 1, 40, lat, nb);
    check("lat_b2b_1", 32'(lat), 32'd9);
    @(negedge clk);
    start_v[0] = 1'b0;
    check("b2b_busy", 32'(busy_v[0]), 32'd1);
    wait_done(0, 1, 40, lat2, nb2);
    check("lat_b2b_2", 32'(lat2), 32'd9);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
